// File: rtl/keypad_operand_fifo.sv
// Keypad entry editor and operand FIFO for the calculator datapath.
// Cursor key presses edit a Digits-nibble entry; EXE commits {operator, operand}
// into a Depth-deep FIFO drained by the ALU. Entry stalls while the FIFO is full
// and auto-commits the frozen word once space frees.
module keypad_operand_fifo #(
  parameter int unsigned Digits = 4,
  parameter int unsigned Depth  = 4,
  parameter int unsigned OpW    = 3,
  localparam int unsigned EntryW = 4 * Digits,
  localparam int unsigned CntW   = $clog2(Depth) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [4:0]        val_i,
  input  logic              btn_p_i,
  input  logic              mode_i,
  input  logic [1:0]        disp_sel_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [EntryW-1:0] out_data_o,
  output logic [OpW-1:0]    out_op_o,
  output logic [CntW-1:0]   count_o,
  output logic              full_o,
  output logic              stall_o,
  output logic              err_o,
  output logic              ovf_o,
  output logic [EntryW-1:0] disp_o
);

  localparam int unsigned PtrW    = $clog2(Depth);
  localparam int unsigned DigW    = $clog2(Digits + 1);
  localparam int unsigned WordW   = OpW + EntryW;
  localparam int unsigned OpFirst = 32'h14;
  localparam int unsigned OpLast  = OpFirst + (1 << OpW) - 1;

  typedef enum logic [0:0] {StEdit, StStall} state_e;

  state_e            state_q, state_d;
  logic [EntryW-1:0] entry_q, entry_d;
  logic [DigW-1:0]   cnt_q, cnt_d;
  logic [OpW-1:0]    op_q, op_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              last_mode_q;
  logic              mode_seen_q;
  logic [EntryW-1:0] disp_q, disp_d;

  logic [WordW-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   count_q;

  logic              push, pop, flush, full, mode_chg;
  logic [WordW-1:0]  push_word;
  logic [WordW-1:0]  head;

  // Key decode
  logic           key_digit, key_exe, key_clr, key_ce, key_bksp, key_op, digit_ok;
  logic [OpW-1:0] op_key;
  assign key_digit = ~val_i[4];
  assign key_exe   = (val_i == 5'h10);
  assign key_clr   = (val_i == 5'h11);
  assign key_ce    = (val_i == 5'h12);
  assign key_bksp  = (val_i == 5'h13);
  assign key_op    = (32'(val_i) >= OpFirst) && (32'(val_i) <= OpLast);
  assign op_key    = OpW'(32'(val_i) - OpFirst);
  assign digit_ok  = mode_i || (val_i[3:0] <= 4'd9);

  assign head     = mem_q[rptr_q];
  assign full     = (count_q == CntW'(Depth));
  assign pop      = out_valid_o & out_ready_i;
  // The first cycle after reset only records the mode; it is not a change.
  assign mode_chg = mode_seen_q && (mode_i != last_mode_q);

  // Next-state logic for the entry editor, operator latch and FSM
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    err_d     = 1'b0;
    ovf_d     = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    push_word = {op_q, entry_q};

    // Mode change acts as CE, but never disturbs a word frozen in STALL.
    if (mode_chg && state_q == StEdit) begin
      entry_d = '0;
      cnt_d   = '0;
    end

    if (btn_p_i) begin
      if (key_clr) begin
        entry_d = '0;
        cnt_d   = '0;
        op_d    = '0;
        flush   = 1'b1;
        state_d = StEdit;
      end else if (state_q == StStall) begin
        err_d = 1'b1;
      end else if (key_digit) begin
        if (!digit_ok) begin
          err_d = 1'b1;
        end else if (cnt_d == DigW'(Digits)) begin
          ovf_d = 1'b1;
        end else begin
          entry_d = {entry_d[EntryW-5:0], val_i[3:0]};
          cnt_d   = cnt_d + DigW'(1);
        end
      end else if (key_bksp) begin
        if (cnt_d != '0) begin
          entry_d = entry_d >> 4;
          cnt_d   = cnt_d - DigW'(1);
        end
      end else if (key_op) begin
        op_d = op_key;
      end else if (key_ce) begin
        entry_d = '0;
        cnt_d   = '0;
      end else if (key_exe) begin
        if (!full || out_ready_i) begin
          push      = 1'b1;
          push_word = {op_q, entry_d};
          entry_d   = '0;
          cnt_d     = '0;
        end else begin
          state_d = StStall;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    // Auto-commit of the frozen word as soon as the FIFO has room.
    if (state_q == StStall && !full && !flush) begin
      push      = 1'b1;
      push_word = {op_q, entry_q};
      entry_d   = '0;
      cnt_d     = '0;
      state_d   = StEdit;
    end
  end

  // Editor, FSM and pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StEdit;
      entry_q     <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      last_mode_q <= 1'b0;
      mode_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      last_mode_q <= mode_i;
      mode_seen_q <= 1'b1;
    end
  end

  // FIFO storage; cleared on reset so no stale word is visible afterwards
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= push_word;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as Depth is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
    end
  end

  // Display source select
  always_comb begin
    disp_d = '0;
    unique case (disp_sel_i)
      2'd0:    disp_d = entry_q;
      2'd1:    disp_d = {{(EntryW - OpW){1'b0}}, op_q};
      2'd2:    disp_d = head[EntryW-1:0];
      default: disp_d = '0;
    endcase
  end

  // Registered display word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) disp_q <= '0;
    else         disp_q <= disp_d;
  end

  assign out_valid_o = (count_q != '0);
  assign out_data_o  = head[EntryW-1:0];
  assign out_op_o    = head[WordW-1:EntryW];
  assign count_o     = count_q;
  assign full_o      = full;
  assign stall_o     = (state_q == StStall);
  assign err_o       = err_q;
  assign ovf_o       = ovf_q;
  assign disp_o      = disp_q;

endmodule

// File: tb/tb_keypad_operand_fifo.sv
// Directed bench for keypad_operand_fifo with a scoreboard of committed words.
module tb_keypad_operand_fifo;

  logic        clk;
  logic        rst_n;
  logic [4:0]  val;
  logic        btn_p;
  logic        mode;
  logic [1:0]  disp_sel;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_op;
  logic [2:0]  count;
  logic        full;
  logic        stall;
  logic        err;
  logic        ovf;
  logic [15:0] disp;

  int checks   = 0;
  int failures = 0;
  logic [18:0] sb[$];

  keypad_operand_fifo #(
    .Digits (4),
    .Depth  (4),
    .OpW    (3)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .val_i       (val),
    .btn_p_i     (btn_p),
    .mode_i      (mode),
    .disp_sel_i  (disp_sel),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_op_o    (out_op),
    .count_o     (count),
    .full_o      (full),
    .stall_o     (stall),
    .err_o       (err),
    .ovf_o       (ovf),
    .disp_o      (disp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [4:0] k);
    val   = k;
    btn_p = 1'b1;
    @(posedge clk);
    #1;
    btn_p = 1'b0;
  endtask

  // Pop one word: compare head against the scoreboard, then accept it.
  task automatic drain_one(input string tag);
    logic [18:0] exp_w;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      exp_w = 'x;
    end else begin
      exp_w = sb.pop_front();
    end
    chk({tag, "_word"}, 32'({out_op, out_data}), 32'(exp_w));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; val = '0; btn_p = 1'b0; mode = 1'b0; disp_sel = 2'd0; out_ready = 1'b0;
    tick(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_disp", 32'(disp), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Decimal entry 1,2,3 then EXE
    press(5'h01); press(5'h02); press(5'h03);
    tick(1);
    chk("entry_123_disp", 32'(disp), 32'h0123);
    press(5'h10);
    sb.push_back({3'd0, 16'h0123});
    chk("exe_valid", 32'(out_valid), 32'd1);
    chk("exe_data", 32'(out_data), 32'h0123);
    chk("exe_op", 32'(out_op), 32'd0);
    chk("exe_count", 32'(count), 32'd1);
    drain_one("pop_123");
    chk("pop_count", 32'(count), 32'd0);

    // Hex digit rejected in decimal, accepted in hex
    press(5'h0B);
    chk("dec_b_err", 32'(err), 32'd1);
    tick(1);
    chk("err_pulse_end", 32'(err), 32'd0);
    chk("dec_b_disp", 32'(disp), 32'h0000);
    mode = 1'b1;
    tick(1);
    press(5'h0B);
    tick(1);
    chk("hex_b_disp", 32'(disp), 32'h000B);

    // Overflow and backspace
    press(5'h12);
    repeat (4) press(5'h09);
    press(5'h09);
    chk("ovf_pulse", 32'(ovf), 32'd1);
    tick(1);
    chk("ovf_pulse_end", 32'(ovf), 32'd0);
    chk("ovf_disp", 32'(disp), 32'h9999);
    press(5'h13);
    tick(1);
    chk("bksp_disp", 32'(disp), 32'h0999);
    for (int i = 0; i < 4; i++) begin
      press(5'h13);
      chk("bksp_no_err", 32'(err), 32'd0);
    end
    tick(1);
    chk("bksp_empty_disp", 32'(disp), 32'h0000);

    // Operator key
    press(5'h16);
    disp_sel = 2'd1;
    tick(1);
    chk("op_disp", 32'(disp), 32'd2);
    disp_sel = 2'd0;
    press(5'h05);
    press(5'h10);
    sb.push_back({3'd2, 16'h0005});
    chk("op_out_op", 32'(out_op), 32'd2);
    chk("op_out_data", 32'(out_data), 32'h0005);
    drain_one("pop_op");

    // Fill FIFO and stall
    for (int i = 1; i <= 5; i++) begin
      press(5'(i));
      press(5'h10);
      sb.push_back({3'd2, 16'(i)});
    end
    chk("stall_full", 32'(full), 32'd1);
    chk("stall_flag", 32'(stall), 32'd1);
    chk("stall_count", 32'(count), 32'd4);
    press(5'h07);
    chk("stall_digit_err", 32'(err), 32'd1);
    drain_one("stall_pop");
    chk("stall_held", 32'(stall), 32'd1);
    tick(1);
    chk("stall_exit", 32'(stall), 32'd0);
    chk("stall_exit_count", 32'(count), 32'd4);
    drain_one("after_stall_pop");
    chk("pre_clr_count", 32'(count), 32'd3);
    press(5'h11);
    sb.delete();
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);

    // Mode change clears entry; disp lags one cycle
    press(5'h04); press(5'h02);
    tick(1);
    chk("entry_42_disp", 32'(disp), 32'h0042);
    mode = 1'b0;
    tick(1);
    chk("mode_chg_lag", 32'(disp), 32'h0042);
    tick(1);
    chk("mode_chg_disp", 32'(disp), 32'h0000);

    // Reset in the middle of STALL
    repeat (5) press(5'h10);
    chk("stall2_flag", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_op", 32'(out_op), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    chk("arst_disp", 32'(disp), 32'd0);
    sb.delete();
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
